// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end and the command RAM checks.
package spi_pkg;

    localparam int RX_W = 10;
    localparam int TX_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Latches one RAM read byte on tx_valid and shifts it out MSB first, once per arming.
module spi_tx_serializer #(
    parameter int TX_W = spi_pkg::TX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arm_i,
    input  logic [TX_W-1:0] tx_data_i,
    input  logic            tx_valid_i,
    output logic            miso_o,
    output logic            done_o
);

    localparam int BW = (TX_W > 1) ? $clog2(TX_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(TX_W - 1);

    logic [TX_W-1:0] sh_q, sh_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            busy_q, busy_d;
    logic            sent_q, sent_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
            sent_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
            sent_q <= sent_d;
        end
    end

    // sent_q blocks a second load while tx_valid stays high after the byte went out.
    always_comb begin
        sh_d   = sh_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        sent_d = sent_q;
        if (!arm_i) begin
            sh_d   = '0;
            bit_d  = '0;
            busy_d = 1'b0;
            sent_d = 1'b0;
        end else if (busy_q) begin
            if (bit_q == LAST_BIT) begin
                sh_d   = '0;
                bit_d  = '0;
                busy_d = 1'b0;
                sent_d = 1'b1;
            end else begin
                sh_d  = {sh_q[TX_W-2:0], 1'b0};
                bit_d = bit_q + BW'(1);
            end
        end else if (!sent_q && tx_valid_i) begin
            sh_d   = tx_data_i;
            bit_d  = '0;
            busy_d = 1'b1;
        end
    end

    assign miso_o = busy_q & sh_q[TX_W-1];
    assign done_o = busy_q && (bit_q == LAST_BIT);

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserialises command words for the command RAM and returns read bytes on MISO.
module spi_slave #(
    parameter int RX_W = spi_pkg::RX_W,
    parameter int TX_W = spi_pkg::TX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    import spi_pkg::*;

    localparam int CW = $clog2(RX_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(RX_W - 1);
    localparam logic [CW-1:0] RX_DONE  = CW'(RX_W);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RX_W-2:0] shift_q, shift_d;
    logic [RX_W-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rd_addr_done_q, rd_addr_done_d;
    logic            tx_arm;
    logic            tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        if (tx_done) begin
            rd_addr_done_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (!SS_n) begin
                    state_d = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_d = IDLE;
                end else if (!MOSI) begin
                    state_d = WRITE;
                end else if (rd_addr_done_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (cnt_q < LAST_BIT) begin
                    shift_d = {shift_q[RX_W-3:0], MOSI};
                    cnt_d   = cnt_q + CW'(1);
                end else if (cnt_q == LAST_BIT) begin
                    // The last bit still completes the word even if SS_n rises on this edge.
                    rx_data_d  = {shift_q, MOSI};
                    rx_valid_d = 1'b1;
                    cnt_d      = RX_DONE;
                    if (state_q == READ_ADD) begin
                        rd_addr_done_d = 1'b1;
                    end
                end
                if (SS_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    assign tx_arm = (state_q == READ_DATA) && (cnt_q == RX_DONE) && !SS_n;

    spi_tx_serializer #(
        .TX_W(TX_W)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm_i     (tx_arm),
        .tx_data_i (tx_data),
        .tx_valid_i(tx_valid),
        .miso_o    (MISO),
        .done_o    (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of full frames plus hand-written abort/reset sequences.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    typedef struct {
        bit         cmd;
        logic [9:0] word;
        logic [7:0] tx;
        int         hold;
        logic [7:0] exp_miso;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete frame; the RAM side offers tx for 'hold' cycles starting after E12.
    task automatic do_frame(input bit cmd, input logic [9:0] w, input logic [7:0] tx,
                            input int hold, output int vcnt, output logic v11,
                            output logic [9:0] rxd, output logic [7:0] mbits, output int stray);
        int tail;
        vcnt = 0;
        stray = 0;
        mbits = '0;
        SS_n = 1'b0; MOSI = 1'b0; tx_valid = 1'b0;
        step();
        vcnt += int'(rx_valid); stray += int'(MISO);
        MOSI = cmd;
        step();
        vcnt += int'(rx_valid); stray += int'(MISO);
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            step();
            vcnt += int'(rx_valid); stray += int'(MISO);
        end
        v11 = rx_valid;
        rxd = rx_data;
        MOSI = 1'b0;
        step();
        vcnt += int'(rx_valid); stray += int'(MISO);
        for (int k = 0; k < 8; k++) begin
            tx_valid = (k < hold);
            tx_data  = (k == 0) ? tx : ~tx;
            step();
            mbits[7-k] = MISO;
            vcnt += int'(rx_valid);
        end
        tail = (hold > 8) ? hold + 4 : 12;
        for (int k = 8; k < tail; k++) begin
            tx_valid = (k < hold);
            tx_data  = ~tx;
            step();
            vcnt += int'(rx_valid); stray += int'(MISO);
        end
        tx_valid = 1'b0;
        SS_n = 1'b1;
        step();
        step();
    endtask

    initial begin
        int         vcnt;
        int         stray;
        int         vseen;
        logic       v11;
        logic [9:0] rxd;
        logic [7:0] mbits;
        logic [9:0] w;

        vecs[0] = '{cmd: 1'b0, word: 10'h0A5, tx: 8'h5A, hold: 1, exp_miso: 8'h00, name: "wr_addr"};
        vecs[1] = '{cmd: 1'b0, word: 10'h13C, tx: 8'hFF, hold: 1, exp_miso: 8'h00, name: "wr_data"};
        vecs[2] = '{cmd: 1'b1, word: 10'h2A5, tx: 8'hFF, hold: 1, exp_miso: 8'h00, name: "rd_addr"};
        vecs[3] = '{cmd: 1'b1, word: 10'h300, tx: 8'h3C, hold: 1, exp_miso: 8'h3C, name: "rd_data"};
        vecs[4] = '{cmd: 1'b1, word: 10'h2A5, tx: 8'hC3, hold: 1, exp_miso: 8'h00, name: "rd_again_is_addr"};
        vecs[5] = '{cmd: 1'b1, word: 10'h3FF, tx: 8'h96, hold: 12, exp_miso: 8'h96, name: "rd_data_hold12"};
        vecs[6] = '{cmd: 1'b0, word: 10'h3C3, tx: 8'hA5, hold: 1, exp_miso: 8'h00, name: "wr_op_unchecked"};

        step();
        step();
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 7; n++) begin
            do_frame(vecs[n].cmd, vecs[n].word, vecs[n].tx, vecs[n].hold, vcnt, v11, rxd, mbits, stray);
            check({vecs[n].name, "_vcnt"}, 32'(vcnt), 32'd1);
            check({vecs[n].name, "_v_at_e11"}, 32'(v11), 32'd1);
            check({vecs[n].name, "_rx_data"}, 32'(rxd), 32'(vecs[n].word));
            check({vecs[n].name, "_miso_bits"}, 32'(mbits), 32'(vecs[n].exp_miso));
            check({vecs[n].name, "_miso_stray"}, 32'(stray), 32'd0);
        end

        // SS_n rises on the same edge as the 10th data bit: word is still delivered.
        w = 10'h155;
        SS_n = 1'b0; MOSI = 1'b0;
        step();
        step();
        for (int i = 9; i >= 1; i--) begin
            MOSI = w[i];
            step();
        end
        MOSI = w[0];
        SS_n = 1'b1;
        step();
        check("ss_edge_valid", 32'(rx_valid), 32'd1);
        check("ss_edge_data", 32'(rx_data), 32'(w));
        step();
        check("ss_edge_valid_drop", 32'(rx_valid), 32'd0);

        // Abort after 5 data bits of a WRITE frame, then a full frame.
        vseen = 0;
        SS_n = 1'b0; MOSI = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'b1;
            step();
            vseen += int'(rx_valid);
        end
        SS_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vseen += int'(rx_valid);
        end
        check("abort_no_valid", 32'(vseen), 32'd0);
        do_frame(1'b0, 10'h1F0, 8'h00, 1, vcnt, v11, rxd, mbits, stray);
        check("after_abort_v_at_e11", 32'(v11), 32'd1);
        check("after_abort_rx_data", 32'(rxd), 32'h1F0);
        check("after_abort_vcnt", 32'(vcnt), 32'd1);

        // Async reset in the middle of shifting read data.
        do_frame(1'b1, 10'h2A5, 8'hFF, 1, vcnt, v11, rxd, mbits, stray);
        check("pre_rst_rd_addr_data", 32'(rxd), 32'h2A5);
        SS_n = 1'b0; MOSI = 1'b0;
        step();
        MOSI = 1'b1;
        step();
        w = 10'h300;
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            step();
        end
        MOSI = 1'b0;
        step();
        tx_valid = 1'b1; tx_data = 8'hF0;
        step();
        check("pre_rst_bit7", 32'(MISO), 32'd1);
        tx_valid = 1'b0;
        step();
        step();
        step();
        check("pre_rst_bit4", 32'(MISO), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", 32'(MISO), 32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        SS_n = 1'b1;
        step();
        check("rst_hold_miso", 32'(MISO), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_release_miso", 32'(MISO), 32'd0);
        check("rst_release_rx_valid", 32'(rx_valid), 32'd0);
        do_frame(1'b1, 10'h2A5, 8'hFF, 1, vcnt, v11, rxd, mbits, stray);
        check("post_rst_is_addr_miso", 32'(mbits), 32'd0);
        check("post_rst_is_addr_stray", 32'(stray), 32'd0);
        check("post_rst_rx_data", 32'(rxd), 32'h2A5);
        do_frame(1'b1, 10'h300, 8'h81, 1, vcnt, v11, rxd, mbits, stray);
        check("post_rst_rd_data_miso", 32'(mbits), 32'h81);
        check("post_rst_rd_data_stray", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave front-end that sits directly upstream of the single-port command RAM.
- Deserialises MOSI frames into 10-bit command words: {op[1:0], payload[7:0]}.
- Presents each word to the RAM with a one-cycle rx_valid pulse.
- For read-data frames, waits for the RAM's tx_valid and serialises the returned 8-bit byte onto MISO, MSB first.
- The SPI clock is the system clock: all sampling happens on posedge clk.

Parameters:
RX_W, 10, command word width (op + address/data) delivered to RAM
TX_W, 8, read-data width returned from RAM and shifted out on MISO

Ports:
clk  input  1  system/SPI clock, all logic on posedge
rst_n  input  1  reset; asynchronous, active-low
SS_n  input  1  slave select, active-low; frame framing
MOSI  input  1  serial data in, sampled on posedge clk
MISO  output  1  serial data out
rx_data  output  RX_W  assembled command word to RAM din
rx_valid  output  1  one-cycle strobe: rx_data is complete
tx_data  input  TX_W  read byte from RAM dout
tx_valid  input  1  RAM read byte valid

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0.
  - rd_addr_done=0; bit counter=0; tx shift reg=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Any illegal encoding goes to IDLE.
- IDLE: SS_n=0 -> CHK_CMD, else stay.
- CHK_CMD: samples the command bit on MOSI.
  - SS_n=1 -> IDLE.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_done=0 -> READ_ADD.
  - MOSI=1 and rd_addr_done=1 -> READ_DATA.
  - The command bit is framing only; it is not stored in rx_data.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift MOSI into the shift register MSB first, one bit per cycle, counter 0..9.
  - On the edge sampling the 10th bit: rx_data <= {shift[8:0], MOSI}; rx_valid <= 1 for exactly one cycle.
- Frame timing, with edge E0 = first edge sampling SS_n=0 in IDLE:
  - E1 samples the command bit.
  - E2..E11 sample data bits.
  - rx_valid is high between E11 and E12.
- Extra bits after the 10th in WRITE/READ_ADD are ignored; the state holds until SS_n=1.
- rd_addr_done:
  - Set on READ_ADD frame completion (the rx_valid edge).
  - Cleared when a READ_DATA frame finishes shifting its 8th MISO bit.
  - Unaffected by aborted frames.
- READ_DATA after rx_valid:
  - Wait sub-phase: the first cycle tx_valid=1 is sampled, latch tx_data.
  - Next 8 cycles: MISO = tx_data[7] down to tx_data[0].
  - Then MISO=0; hold until SS_n=1.
  - tx_valid staying high does not relatch.
  - With the RAM's 1-cycle latency: tx_valid is sampled at E13, MISO carries bit7 after E13, bit0 after E20, and returns to 0 after E21.
- Wait for tx_valid is unbounded; SS_n=1 aborts it.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; counter and shift register are cleared; MISO=0.
  - A partial frame produces no rx_valid.
  - If SS_n rises on the same edge the 10th bit is sampled, the word is still delivered (rx_valid fires).
- MISO=0 whenever not shifting read data.
- rx_data is not validated: op bits pass to the RAM as received.
- Reset mid-frame: immediate return to reset values; no rx_valid and no MISO glitch after release.

Decomposition:
- Shared package spi_pkg holds:
  - state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - RX_W/TX_W constants.
  - op encodings OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11. These are also used by the RAM checks.
- One natural sub-module: spi_tx_serializer.
  - Loads tx_data on tx_valid.
  - Shifts out 8 bits MSB first.
  - Signals done to clear rd_addr_done.

Test Plan:
1. Write-address frame: SS_n low, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5 with rx_valid high exactly one cycle (E11..E12); MISO stays 0.
2. Write-data then read-address then read-data, with the RAM model (addr 0xA5 <= 0x3C):
   - READ_ADD frame 10_1010_0101 sets rd_addr_done.
   - Next frame (command bit 1) enters READ_DATA, sends 11_0000_0000.
   - MISO shows 0,0,1,1,1,1,0,0 on the cycles after E13..E20.
   - rd_addr_done clears afterwards.
3. Abort: SS_n high after 5 data bits of a WRITE frame -> no rx_valid, state IDLE next cycle; following full frame 01_1111_0000 -> rx_data=10'h1F0.
4. Second command-1 frame without a prior READ_ADD after a completed read -> goes to READ_ADD, not READ_DATA; no MISO activity.
5. Async reset asserted mid READ_DATA shifting (after bit 3) -> MISO=0 and rx_valid=0 immediately, rd_addr_done=0; next read-command frame treated as READ_ADD.
6. tx_valid held high for 12 cycles -> tx_data latched once only, exactly 8 MISO bits, then MISO=0.
